// File: rtl/spi_pkg.sv
// Shared state encoding and framing constants for the SPI shift engine.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE,
        SHIFT
    } spi_state_e;

    localparam int unsigned BITS_PER_BYTE  = 8;
    localparam int unsigned EDGES_PER_BYTE = 16;

endpackage

// File: rtl/spi_edge_gen.sv
// SPI clock generator: half-period counter, spi_clk toggle and per-byte edge counter.
module spi_edge_gen
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic start_i,
    output logic spi_clk_o,
    output logic rise_o,
    output logic fall_o,
    output logic edge_zero_o,
    output logic last_cycle_o
);

    localparam int unsigned CntW = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
    localparam logic [CntW-1:0] HalfMax = CntW'(CLKS_PER_HALF_BIT - 1);
    localparam logic [CntW-1:0] HalfPre = CntW'(CLKS_PER_HALF_BIT - 2);
    localparam logic [4:0] EdgeLoad = 5'(EDGES_PER_BYTE);

    logic [CntW-1:0] half_q, half_d;
    logic [4:0]      edge_q, edge_d;
    logic            clk_q, clk_d;
    logic            active;
    logic            toggle;

    // The counter keeps running until the 16th toggle, even after the top has
    // already returned to IDLE one cycle earlier.
    assign active       = (edge_q != 5'd0);
    assign toggle       = active && (half_q == HalfMax);
    assign rise_o       = toggle && !clk_q;
    assign fall_o       = toggle && clk_q;
    assign edge_zero_o  = (edge_q == 5'd1);
    // Cycle before the final falling toggle: lets the next byte be accepted
    // on that very toggle so bytes follow with no spi_clk gap.
    assign last_cycle_o = (edge_q == 5'd1) && (half_q == HalfPre);
    assign spi_clk_o    = clk_q;

    // Next-state for the half counter, edge counter and spi_clk.
    always_comb begin
        half_d = half_q;
        edge_d = edge_q;
        clk_d  = clk_q;
        if (start_i) begin
            half_d = '0;
            edge_d = EdgeLoad;
            clk_d  = 1'b0;
        end else if (active) begin
            if (toggle) begin
                half_d = '0;
                edge_d = edge_q - 5'd1;
                clk_d  = ~clk_q;
            end else begin
                half_d = half_q + CntW'(1);
            end
        end
    end

    // Counter and spi_clk registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            half_q <= '0;
            edge_q <= 5'd0;
            clk_q  <= 1'b0;
        end else begin
            half_q <= half_d;
            edge_q <= edge_d;
            clk_q  <= clk_d;
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// Byte-level SPI mode-0 master, MSB first, full duplex.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int unsigned CLKS_PER_HALF_BIT = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [BITS_PER_BYTE-1:0] tx_byte,
    input  logic                     tx_dv,
    output logic                     tx_ready,
    output logic                     rx_dv,
    output logic [BITS_PER_BYTE-1:0] rx_byte,
    output logic                     spi_clk,
    input  logic                     spi_miso,
    output logic                     spi_mosi
);

    spi_state_e               state_q, state_d;
    logic [BITS_PER_BYTE-1:0] tx_sr_q, tx_sr_d;
    logic [BITS_PER_BYTE-1:0] rx_sr_q, rx_sr_d;
    logic [BITS_PER_BYTE-1:0] rx_byte_q, rx_byte_d;
    logic                     mosi_q, mosi_d;
    logic                     rx_dv_q, rx_dv_d;
    logic                     accept;
    logic                     rise, fall, edge_zero, last_cycle;

    assign tx_ready = (state_q == IDLE);
    assign accept   = tx_dv && tx_ready;
    assign rx_dv    = rx_dv_q;
    assign rx_byte  = rx_byte_q;
    assign spi_mosi = mosi_q;

    spi_edge_gen #(
        .CLKS_PER_HALF_BIT(CLKS_PER_HALF_BIT)
    ) u_edge_gen (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (accept),
        .spi_clk_o   (spi_clk),
        .rise_o      (rise),
        .fall_o      (fall),
        .edge_zero_o (edge_zero),
        .last_cycle_o(last_cycle)
    );

    // Handshake FSM, MISO sampling and MOSI shifting.
    always_comb begin
        state_d   = state_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        rx_byte_d = rx_byte_q;
        mosi_d    = mosi_q;
        rx_dv_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (tx_dv) state_d = SHIFT;
            end
            SHIFT: begin
                if (last_cycle) begin
                    state_d   = IDLE;
                    rx_dv_d   = 1'b1;
                    rx_byte_d = rx_sr_q;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rise) rx_sr_d = {rx_sr_q[BITS_PER_BYTE-2:0], spi_miso};

        // A new byte's MSB takes priority over idling MOSI on the final fall.
        if (accept) begin
            tx_sr_d = tx_byte;
            mosi_d  = tx_byte[BITS_PER_BYTE-1];
        end else if (fall) begin
            if (edge_zero) begin
                mosi_d = 1'b0;
            end else begin
                mosi_d  = tx_sr_q[BITS_PER_BYTE-2];
                tx_sr_d = {tx_sr_q[BITS_PER_BYTE-2:0], 1'b0};
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            rx_byte_q <= '0;
            mosi_q    <= 1'b0;
            rx_dv_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            rx_byte_q <= rx_byte_d;
            mosi_q    <= mosi_d;
            rx_dv_q   <= rx_dv_d;
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: one H=2 instance (MISO looped to MOSI)
// and one H=3 instance driven by a small slave model.
// Sample index k counts clk rising edges after the accept edge E0 (k=0 is the
// negedge right after E0). The completion cycle (rx_dv=1, tx_ready=1) is the
// one closed by edge E0+16H, so it is seen at k=16H-1 and a held tx_dv is
// accepted on E0+16H.
module tb_spi_shift_engine;

    logic       clk;
    logic       resetn;

    logic [7:0] tx_byte2, rx_byte2;
    logic       tx_dv2, tx_ready2, rx_dv2, spi_clk2, spi_miso2, spi_mosi2;
    logic [7:0] tx_byte3, rx_byte3;
    logic       tx_dv3, tx_ready3, rx_dv3, spi_clk3, spi_miso3, spi_mosi3;

    int         checks;
    int         errors;
    int         cyc;
    int         acc_cnt;
    int         acc_last;
    int         acc_prev;
    logic [7:0] slv_sr3;
    logic       slv_en3;

    spi_shift_engine #(.CLKS_PER_HALF_BIT(2)) dut2 (
        .clk     (clk),
        .resetn  (resetn),
        .tx_byte (tx_byte2),
        .tx_dv   (tx_dv2),
        .tx_ready(tx_ready2),
        .rx_dv   (rx_dv2),
        .rx_byte (rx_byte2),
        .spi_clk (spi_clk2),
        .spi_miso(spi_miso2),
        .spi_mosi(spi_mosi2)
    );

    spi_shift_engine #(.CLKS_PER_HALF_BIT(3)) dut3 (
        .clk     (clk),
        .resetn  (resetn),
        .tx_byte (tx_byte3),
        .tx_dv   (tx_dv3),
        .tx_ready(tx_ready3),
        .rx_dv   (rx_dv3),
        .rx_byte (rx_byte3),
        .spi_clk (spi_clk3),
        .spi_miso(spi_miso3),
        .spi_mosi(spi_mosi3)
    );

    assign spi_miso2 = spi_mosi2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Acceptance monitor for the H=2 instance.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (tx_dv2 && tx_ready2) begin
            acc_prev = acc_last;
            acc_last = cyc;
            acc_cnt  = acc_cnt + 1;
        end
    end

    // Slave model: next bit on each falling spi_clk.
    always @(negedge spi_clk3) begin
        if (slv_en3) begin
            slv_sr3   = {slv_sr3[6:0], 1'b0};
            spi_miso3 = slv_sr3[7];
        end
    end

    function automatic logic exp_clk(input int k, input int h, input int nbytes);
        return (k < 16 * h * nbytes) && (((k / h) % 2) == 1);
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        #1;
        checks++;
        if (tx_ready2 !== 1'b1 || spi_clk2 !== 1'b0 || spi_mosi2 !== 1'b0 || rx_dv2 !== 1'b0
            || rx_byte2 !== 8'h00) begin
            errors++;
            $display("FAIL reset_h2: got ready=%b clk=%b mosi=%b dv=%b byte=%h, want 1 0 0 0 00",
                     tx_ready2, spi_clk2, spi_mosi2, rx_dv2, rx_byte2);
        end
        checks++;
        if (tx_ready3 !== 1'b1 || spi_clk3 !== 1'b0 || spi_mosi3 !== 1'b0 || rx_dv3 !== 1'b0
            || rx_byte3 !== 8'h00) begin
            errors++;
            $display("FAIL reset_h3: got ready=%b clk=%b mosi=%b dv=%b byte=%h, want 1 0 0 0 00",
                     tx_ready3, spi_clk3, spi_mosi3, rx_dv3, rx_byte3);
        end
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            checks++;
            if (tx_ready2 !== 1'b1 || spi_clk2 !== 1'b0 || spi_mosi2 !== 1'b0 || rx_dv2 !== 1'b0)
            begin
                errors++;
                $display("FAIL idle_after_reset cyc %0d: got ready=%b clk=%b mosi=%b dv=%b, want 1 0 0 0",
                         i, tx_ready2, spi_clk2, spi_mosi2, rx_dv2);
            end
        end
    endtask

    task automatic test_loopback_a5();
        logic [7:0] b;
        logic       em;
        int         dv_cnt;
        b      = 8'hA5;
        dv_cnt = 0;
        @(negedge clk);
        tx_byte2 = b;
        tx_dv2   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_dv2   = 1'b0;
                tx_byte2 = 8'h00;   // late change must not matter
            end
            em = (k < 32) ? b[7 - k / 4] : 1'b0;
            if (rx_dv2 === 1'b1) dv_cnt++;
            checks++;
            if (spi_mosi2 !== em) begin
                errors++;
                $display("FAIL a5_mosi k=%0d: got %b want %b", k, spi_mosi2, em);
            end
            checks++;
            if (spi_clk2 !== exp_clk(k, 2, 1)) begin
                errors++;
                $display("FAIL a5_spi_clk k=%0d: got %b want %b", k, spi_clk2, exp_clk(k, 2, 1));
            end
            checks++;
            if (rx_dv2 !== (k == 31)) begin
                errors++;
                $display("FAIL a5_rx_dv k=%0d: got %b want %b", k, rx_dv2, (k == 31));
            end
            checks++;
            if (tx_ready2 !== (k >= 31)) begin
                errors++;
                $display("FAIL a5_tx_ready k=%0d: got %b want %b", k, tx_ready2, (k >= 31));
            end
        end
        checks++;
        if (rx_byte2 !== 8'hA5) begin
            errors++;
            $display("FAIL a5_rx_byte: got %h want a5", rx_byte2);
        end
        checks++;
        if (dv_cnt != 1) begin
            errors++;
            $display("FAIL a5_rx_dv_count: got %0d want 1", dv_cnt);
        end
    endtask

    task automatic test_slave_h3();
        logic em;
        logic prev_clk;
        int   pulses;
        int   dv_cnt;
        logic [7:0] b;
        b      = 8'h3C;
        pulses = 0;
        dv_cnt = 0;
        @(negedge clk);
        slv_sr3   = 8'hC3;
        spi_miso3 = 1'b1;
        slv_en3   = 1'b1;
        tx_byte3  = b;
        tx_dv3    = 1'b1;
        @(posedge clk);
        prev_clk = 1'b0;
        for (int k = 0; k < 52; k++) begin
            @(negedge clk);
            if (k == 0) tx_dv3 = 1'b0;
            if (spi_clk3 === 1'b1 && prev_clk === 1'b0) pulses++;
            prev_clk = spi_clk3;
            if (rx_dv3 === 1'b1) dv_cnt++;
            em = (k < 48) ? b[7 - k / 6] : 1'b0;
            checks++;
            if (spi_clk3 !== exp_clk(k, 3, 1)) begin
                errors++;
                $display("FAIL h3_spi_clk k=%0d: got %b want %b", k, spi_clk3, exp_clk(k, 3, 1));
            end
            checks++;
            if (spi_mosi3 !== em) begin
                errors++;
                $display("FAIL h3_mosi k=%0d: got %b want %b", k, spi_mosi3, em);
            end
            checks++;
            if (rx_dv3 !== (k == 47)) begin
                errors++;
                $display("FAIL h3_rx_dv k=%0d: got %b want %b", k, rx_dv3, (k == 47));
            end
        end
        slv_en3 = 1'b0;
        checks++;
        if (pulses != 8) begin
            errors++;
            $display("FAIL h3_pulse_count: got %0d want 8", pulses);
        end
        checks++;
        if (rx_byte3 !== 8'hC3) begin
            errors++;
            $display("FAIL h3_rx_byte: got %h want c3", rx_byte3);
        end
        checks++;
        if (dv_cnt != 1) begin
            errors++;
            $display("FAIL h3_rx_dv_count: got %0d want 1", dv_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] cur;
        logic       em;
        int         acc0;
        int         dv_cnt;
        logic       er;
        dv_cnt = 0;
        @(negedge clk);
        acc0     = acc_cnt;
        tx_byte2 = 8'h01;
        tx_dv2   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 68; k++) begin
            @(negedge clk);
            if (k == 0) tx_byte2 = 8'h80;
            if (k == 32) tx_dv2 = 1'b0;
            cur = (k < 32) ? 8'h01 : 8'h80;
            em  = (k < 64) ? cur[7 - (k % 32) / 4] : 1'b0;
            er  = (k == 31) || (k >= 63);
            if (rx_dv2 === 1'b1) begin
                dv_cnt++;
                checks++;
                if (rx_byte2 !== cur) begin
                    errors++;
                    $display("FAIL b2b_rx_byte k=%0d: got %h want %h", k, rx_byte2, cur);
                end
            end
            checks++;
            if (spi_clk2 !== exp_clk(k, 2, 2)) begin
                errors++;
                $display("FAIL b2b_spi_clk k=%0d: got %b want %b", k, spi_clk2, exp_clk(k, 2, 2));
            end
            checks++;
            if (spi_mosi2 !== em) begin
                errors++;
                $display("FAIL b2b_mosi k=%0d: got %b want %b", k, spi_mosi2, em);
            end
            checks++;
            if (tx_ready2 !== er) begin
                errors++;
                $display("FAIL b2b_tx_ready k=%0d: got %b want %b", k, tx_ready2, er);
            end
        end
        checks++;
        if (acc_cnt - acc0 != 2) begin
            errors++;
            $display("FAIL b2b_accept_count: got %0d want 2", acc_cnt - acc0);
        end
        checks++;
        if (acc_last - acc_prev != 32) begin
            errors++;
            $display("FAIL b2b_accept_spacing: got %0d want 32", acc_last - acc_prev);
        end
        checks++;
        if (dv_cnt != 2) begin
            errors++;
            $display("FAIL b2b_rx_dv_count: got %0d want 2", dv_cnt);
        end
    endtask

    task automatic test_ignore_busy();
        int acc0;
        int dv_cnt;
        dv_cnt = 0;
        @(negedge clk);
        acc0     = acc_cnt;
        tx_byte2 = 8'h00;
        tx_dv2   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 36; k++) begin
            @(negedge clk);
            if (k == 0) tx_dv2 = 1'b0;
            if (k == 4) begin
                tx_byte2 = 8'hFF;
                tx_dv2   = 1'b1;    // seen at E0+5
            end
            if (k == 5) tx_dv2 = 1'b0;
            if (rx_dv2 === 1'b1) dv_cnt++;
            checks++;
            if (spi_mosi2 !== 1'b0) begin
                errors++;
                $display("FAIL ign_mosi k=%0d: got %b want 0", k, spi_mosi2);
            end
            checks++;
            if (spi_clk2 !== exp_clk(k, 2, 1)) begin
                errors++;
                $display("FAIL ign_spi_clk k=%0d: got %b want %b", k, spi_clk2, exp_clk(k, 2, 1));
            end
        end
        checks++;
        if (dv_cnt != 1) begin
            errors++;
            $display("FAIL ign_rx_dv_count: got %0d want 1", dv_cnt);
        end
        checks++;
        if (acc_cnt - acc0 != 1) begin
            errors++;
            $display("FAIL ign_accept_count: got %0d want 1", acc_cnt - acc0);
        end
        checks++;
        if (rx_byte2 !== 8'h00) begin
            errors++;
            $display("FAIL ign_rx_byte: got %h want 00", rx_byte2);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        logic       em;
        int         dv_cnt;
        dv_cnt = 0;
        @(negedge clk);
        tx_byte2 = 8'hFF;
        tx_dv2   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_dv2 = 1'b0;
        repeat (11) @(posedge clk);   // edge E0+11
        #1;
        checks++;
        if (spi_clk2 !== 1'b1 || spi_mosi2 !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: got clk=%b mosi=%b want 1 1", spi_clk2, spi_mosi2);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (spi_clk2 !== 1'b0 || spi_mosi2 !== 1'b0 || tx_ready2 !== 1'b1 || rx_dv2 !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async: got clk=%b mosi=%b ready=%b dv=%b want 0 0 1 0",
                     spi_clk2, spi_mosi2, tx_ready2, rx_dv2);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_dv2 === 1'b1) dv_cnt++;
        end
        checks++;
        if (dv_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_no_rx_dv: got %0d pulses want 0", dv_cnt);
        end
        b        = 8'h5A;
        tx_byte2 = b;
        tx_dv2   = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 34; k++) begin
            @(negedge clk);
            if (k == 0) tx_dv2 = 1'b0;
            em = (k < 32) ? b[7 - k / 4] : 1'b0;
            checks++;
            if (spi_mosi2 !== em) begin
                errors++;
                $display("FAIL rst_5a_mosi k=%0d: got %b want %b", k, spi_mosi2, em);
            end
            checks++;
            if (rx_dv2 !== (k == 31)) begin
                errors++;
                $display("FAIL rst_5a_rx_dv k=%0d: got %b want %b", k, rx_dv2, (k == 31));
            end
        end
        checks++;
        if (rx_byte2 !== 8'h5A) begin
            errors++;
            $display("FAIL rst_5a_rx_byte: got %h want 5a", rx_byte2);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        acc_cnt   = 0;
        acc_last  = 0;
        acc_prev  = 0;
        tx_byte2  = 8'h00;
        tx_dv2    = 1'b0;
        tx_byte3  = 8'h00;
        tx_dv3    = 1'b0;
        spi_miso3 = 1'b0;
        slv_sr3   = 8'h00;
        slv_en3   = 1'b0;
        resetn    = 1'b0;
        test_reset();
        test_loopback_a5();
        test_slave_h3();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1);
    end

endmodule
